// File: rtl/fetch_q_pkg.sv
// rtl/fetch_q_pkg.sv - shared defaults and encodings for the fetch unit
package fetch_q_pkg;

  localparam int unsigned DEF_AW       = 32;
  localparam int unsigned DEF_IW       = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  // Canonical no-op (addi x0, x0, 0) for consumers that need a filler word.
  localparam logic [31:0] NOP_INS      = 32'h0000_0013;

endpackage

// File: rtl/fetch_q_fifo.sv
// rtl/fetch_q_fifo.sv - synchronous prefetch FIFO with clear, occupancy and head outputs
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [CW-1:0] occ,
  output logic          head_valid,
  output logic [W-1:0]  head_data
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic          pop_ok;

  assign pop_ok     = pop && (occ_q != '0);
  assign occ        = occ_q;
  assign head_valid = (occ_q != '0);
  // Head reads zero when empty so the outputs stay quiet between bursts.
  assign head_data  = head_valid ? mem_q[rd_q] : '0;

  // Next-state: clear wins over push/pop; pointers wrap since DEPTH is a power of 2.
  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    occ_d = occ_q;
    if (clear) begin
      rd_d  = '0;
      wr_d  = '0;
      occ_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_d = rd_q + PW'(1);
      end
      occ_d = occ_q + CW'(push) - CW'(pop_ok);
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      occ_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      occ_q <= occ_d;
    end
  end

  // Storage is pure datapath and needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // A push into a full queue means the upstream credit logic is broken.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !clear && (occ_q == CW'(DEPTH))));

endmodule

// File: rtl/fetch_q.sv
// rtl/fetch_q.sv - instruction fetch unit with credit-controlled prefetch queue
module fetch_q
  import fetch_q_pkg::*;
#(
  parameter int unsigned   AW       = DEF_AW,
  parameter int unsigned   IW       = DEF_IW,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = AW'(DEF_RESET_PC),
  parameter bit            REL_JMP  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          redirect_en,
  input  logic [AW-1:0] redirect_addr,
  output logic          imem_en,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_ins,
  output logic [AW-1:0] out_pc
);

  localparam int unsigned   CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

  logic [AW-1:0]    pc_q, pc_d;
  logic [AW-1:0]    req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic             drop_q, drop_d;
  logic [CW-1:0]    occ;
  logic             restart;
  logic             credit;
  logic             push;
  logic [AW-1:0]    target;
  logic [IW+AW-1:0] head_data;

  assign restart = flush || redirect_en;
  // Registered occupancy plus the outstanding request must leave room for its response.
  assign credit  = ({1'b0, occ} + {{CW{1'b0}}, inflight_q}) < DEPTH_C;
  assign imem_en   = !rst && !restart && credit;
  assign imem_addr = pc_q;
  assign push      = inflight_q && !drop_q;
  assign target    = REL_JMP ? (out_pc + redirect_addr) : redirect_addr;
  assign out_ins   = head_data[IW+AW-1:AW];
  assign out_pc    = head_data[AW-1:0];

  // PC / request tracking: flush beats redirect beats sequential issue.
  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    drop_d     = 1'b0;
    if (flush) begin
      pc_d   = RESET_PC;
      drop_d = inflight_q;
    end else if (redirect_en) begin
      pc_d   = target;
      drop_d = inflight_q;
    end else if (imem_en) begin
      pc_d       = pc_q + AW'(1);
      req_pc_d   = pc_q;
      inflight_d = 1'b1;
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (IW + AW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clear      (restart),
    .push       (push),
    .push_data  ({imem_rdata, req_pc_q}),
    .pop        (out_ready),
    .occ        (occ),
    .head_valid (out_valid),
    .head_data  (head_data)
  );

  // A relative jump needs a valid head to take its base address from.
  a_rel_needs_head : assert property (@(posedge clk) disable iff (rst)
    (REL_JMP && redirect_en && !flush) |-> out_valid);

endmodule

// File: tb/tb_fetch_q.sv
// tb/tb_fetch_q.sv - directed self-checking bench for fetch_q
module tb_fetch_q;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        flush_r = 1'b0, redirect_en_r = 1'b0, out_ready_r = 1'b1;
  logic [31:0] redirect_addr_r = '0;
  logic        imem_en_r, out_valid_r;
  logic [31:0] imem_addr_r, out_ins_r, out_pc_r;
  logic [31:0] imem_rdata_r = '0;

  logic        flush_a = 1'b0, redirect_en_a = 1'b0, out_ready_a = 1'b1;
  logic [7:0]  redirect_addr_a = '0;
  logic        imem_en_a, out_valid_a;
  logic [7:0]  imem_addr_a, out_pc_a;
  logic [31:0] out_ins_a;
  logic [31:0] imem_rdata_a = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_q #(.AW(32), .IW(32), .DEPTH(4), .RESET_PC(32'h0), .REL_JMP(1'b1)) u_rel (
    .clk(clk), .rst(rst), .flush(flush_r), .redirect_en(redirect_en_r),
    .redirect_addr(redirect_addr_r), .imem_en(imem_en_r), .imem_addr(imem_addr_r),
    .imem_rdata(imem_rdata_r), .out_valid(out_valid_r), .out_ready(out_ready_r),
    .out_ins(out_ins_r), .out_pc(out_pc_r)
  );

  fetch_q #(.AW(8), .IW(32), .DEPTH(4), .RESET_PC(8'hFE), .REL_JMP(1'b0)) u_abs (
    .clk(clk), .rst(rst), .flush(flush_a), .redirect_en(redirect_en_a),
    .redirect_addr(redirect_addr_a), .imem_en(imem_en_a), .imem_addr(imem_addr_a),
    .imem_rdata(imem_rdata_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_ins(out_ins_a), .out_pc(out_pc_a)
  );

  // Single-cycle memories: relative unit returns word = addr, absolute unit tags it.
  always @(posedge clk) begin
    if (imem_en_r) imem_rdata_r <= imem_addr_r;
    if (imem_en_a) imem_rdata_a <= 32'hCAFE_0000 | {24'h0, imem_addr_a};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    step(); step();
    check("rst_imem_en", imem_en_r, 0);
    check("rst_imem_addr", imem_addr_r, 0);
    check("rst_out_valid", out_valid_r, 0);
    check("rst_out_ins", out_ins_r, 0);
    check("rst_out_pc", out_pc_r, 0);
    check("rst_abs_addr", imem_addr_a, 8'hFE);

    // Streaming with out_ready high
    rst = 1'b0; #1;
    check("c0_imem_en", imem_en_r, 1);
    check("c0_imem_addr", imem_addr_r, 0);
    check("c0_out_valid", out_valid_r, 0);
    step();
    check("c1_out_valid", out_valid_r, 0);
    step();
    check("c2_out_valid", out_valid_r, 1);
    check("c2_out_pc", out_pc_r, 0);
    check("c2_out_ins", out_ins_r, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("stream_valid", out_valid_r, 1);
      check("stream_pc", out_pc_r, k);
      check("stream_ins", out_ins_r, k);
    end

    // Relative redirect from head pc=5 by 0x10
    redirect_en_r = 1'b1; redirect_addr_r = 32'h10; #1;
    check("redir_no_issue", imem_en_r, 0);
    step();
    redirect_en_r = 1'b0; redirect_addr_r = '0; #1;
    check("redir_r1_valid", out_valid_r, 0);
    check("redir_r1_addr", imem_addr_r, 32'h15);
    check("redir_r1_en", imem_en_r, 1);
    step();
    check("redir_r2_valid", out_valid_r, 0);
    step();
    check("redir_r3_valid", out_valid_r, 1);
    check("redir_r3_pc", out_pc_r, 32'h15);
    check("redir_r3_ins", out_ins_r, 32'h15);
    step();
    check("redir_r4_pc", out_pc_r, 32'h16);

    // Backpressure from reset
    rst = 1'b1; out_ready_r = 1'b0;
    step(); step();
    rst = 1'b0; #1;
    repeat (10) step();
    check("bp_occ", u_rel.occ, 4);
    check("bp_imem_en", imem_en_r, 0);
    check("bp_pc", imem_addr_r, 4);
    check("bp_head_pc", out_pc_r, 0);
    out_ready_r = 1'b1; #1;
    for (int k = 0; k < 8; k++) begin
      check("bp_rel_valid", out_valid_r, 1);
      check("bp_rel_pc", out_pc_r, k);
      check("bp_rel_ins", out_ins_r, k);
      step();
    end

    // Reset while 3 entries queued and a request in flight
    rst = 1'b1; out_ready_r = 1'b0;
    step(); step();
    rst = 1'b0; #1;
    repeat (4) step();
    check("mr_occ", u_rel.occ, 3);
    check("mr_imem_en", imem_en_r, 0);
    rst = 1'b1; out_ready_r = 1'b1;
    step();
    check("mr_valid", out_valid_r, 0);
    check("mr_addr", imem_addr_r, 0);
    rst = 1'b0; #1;
    check("mr_c0_en", imem_en_r, 1);
    step();
    check("mr_c1_valid", out_valid_r, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("mr_valid_seq", out_valid_r, 1);
      check("mr_pc_seq", out_pc_r, k);
    end

    // Address wrap on the 8-bit absolute unit
    rst = 1'b1;
    step(); step();
    rst = 1'b0; out_ready_a = 1'b1; #1;
    step(); step();
    check("wrap_fe_pc", out_pc_a, 8'hFE);
    check("wrap_fe_ins", out_ins_a, 32'hCAFE_00FE);
    step();
    check("wrap_ff_pc", out_pc_a, 8'hFF);
    step();
    check("wrap_00_pc", out_pc_a, 8'h00);
    check("wrap_00_ins", out_ins_a, 32'hCAFE_0000);
    step();
    check("wrap_01_pc", out_pc_a, 8'h01);

    // Flush and absolute redirect together: flush wins
    flush_a = 1'b1; redirect_en_a = 1'b1; redirect_addr_a = 8'h40; #1;
    check("fl_no_issue", imem_en_a, 0);
    step();
    flush_a = 1'b0; redirect_en_a = 1'b0; redirect_addr_a = '0; #1;
    check("fl_r1_addr", imem_addr_a, 8'hFE);
    check("fl_r1_valid", out_valid_a, 0);
    step();
    check("fl_r2_valid", out_valid_a, 0);
    step();
    check("fl_r3_valid", out_valid_a, 1);
    check("fl_r3_pc", out_pc_a, 8'hFE);
    step();
    check("fl_r4_pc", out_pc_a, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
